dmem_arbiter: RTL and testbench

//  Shares the single-port data RAM between two requesters: m0 = core load/store unit, m1 = debug/program loader.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_arbiter_rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states,
// byte-enable constants and the sub-word merge used by read-modify-write stores.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    MWR  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // Lane-wise merge: enabled lanes take the new byte, the rest keep the old one.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  function automatic logic be_partial(input logic [3:0] be);
    return (be != BE_FULL) && (be != BE_NONE);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       rr_last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (advance_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = rr_last_i ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port 32-bit data RAM between the LSU (m0) and the debug
// loader (m1); sub-word stores are executed as read-modify-write.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int   AW       = 9,
  parameter logic RR_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset_i,

  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [31:0]   m0_addr_i,
  input  logic [31:0]   m0_wdata_i,
  input  logic [3:0]    m0_be_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [31:0]   m0_rdata_o,

  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [31:0]   m1_addr_i,
  input  logic [31:0]   m1_wdata_i,
  input  logic [3:0]    m1_be_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [31:0]   m1_rdata_o,

  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_data_o,
  output logic          ram_we_o,
  input  logic [31:0]   ram_data_i
);

  state_e        state_q, state_d;
  logic [1:0]    gnt;
  logic          grant_any;
  logic          grant_id;

  logic          id_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q;
  logic [31:0]   ram_data_q;
  logic          rr_last_q;

  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;
  logic          partial_q;
  logic          rv0, rv1;

  // Only bits [AW+1:2] form the word index; the rest are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr_i[31:AW+2], m0_addr_i[1:0],
                              m1_addr_i[31:AW+2], m1_addr_i[1:0]};

  rr_arb2 u_rr_arb2 (
    .req_i     ({m1_req_i, m0_req_i}),
    .advance_i ((state_q == IDLE) && !reset_i),
    .rr_last_i (rr_last_q),
    .gnt_o     (gnt)
  );

  assign grant_any = |gnt;
  assign grant_id  = gnt[1];

  assign sel_we    = grant_id ? m1_we_i    : m0_we_i;
  assign sel_addr  = grant_id ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = grant_id ? m1_wdata_i : m0_wdata_i;
  assign sel_be    = grant_id ? m1_be_i    : m0_be_i;
  assign partial_q = we_q && be_partial(be_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_any) state_d = ACC;
      ACC:     state_d = partial_q ? MWR : DONE;
      MWR:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latches; ram_data_q doubles as the RAM write-data register so
  // the RAM data bus holds its last value while idle.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= BE_NONE;
      rdata_q    <= '0;
      ram_data_q <= '0;
      rr_last_q  <= RR_RESET;
    end else begin
      if (grant_any) begin
        id_q      <= grant_id;
        we_q      <= sel_we;
        addr_q    <= sel_addr[AW+1:2];
        wdata_q   <= sel_wdata;
        be_q      <= sel_be;
        rr_last_q <= grant_id;
        if (sel_we) ram_data_q <= sel_wdata;
      end
      if (state_q == ACC) begin
        if (!we_q || partial_q) rdata_q <= ram_data_i;
        if (partial_q) ram_data_q <= be_merge(ram_data_i, wdata_q, be_q);
      end
    end
  end

  // Output logic
  always_comb begin
    ram_we_o = 1'b0;
    rv0      = 1'b0;
    rv1      = 1'b0;
    unique case (state_q)
      ACC:     ram_we_o = we_q && (be_q == BE_FULL);
      MWR:     ram_we_o = 1'b1;
      DONE:    begin
        rv0 = !id_q;
        rv1 = id_q;
      end
      default: ;
    endcase
    if (reset_i) begin
      ram_we_o = 1'b0;
      rv0      = 1'b0;
      rv1      = 1'b0;
    end
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rv0;
  assign m1_rvalid_o = rv1;
  assign m0_rdata_o  = (rv0 && !we_q) ? rdata_q : 32'h0;
  assign m1_rdata_o  = (rv1 && !we_q) ? rdata_q : 32'h0;
  assign ram_addr_o  = addr_q;
  assign ram_data_o  = ram_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a combinational-read RAM model;
// expected values are hand-computed per transaction.
module tb_dmem_arbiter;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [31:0]   addr  [2];
  logic [31:0]   wdata [2];
  logic [3:0]    be    [2];

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          ram_we;

  logic [31:0]   mem [512];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  dmem_arbiter #(.AW(AW), .RR_RESET(1'b1)) dut (
    .clk         (clk),
    .reset_i     (reset),
    .m0_req_i    (req[0]),
    .m0_we_i     (we[0]),
    .m0_addr_i   (addr[0]),
    .m0_wdata_i  (wdata[0]),
    .m0_be_i     (be[0]),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (req[1]),
    .m1_we_i     (we[1]),
    .m1_addr_i   (addr[1]),
    .m1_wdata_i  (wdata[1]),
    .m1_be_i     (be[1]),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .ram_addr_o  (ram_addr),
    .ram_data_o  (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_data_i  (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic gnt_of(input int m);
    return (m == 0) ? m0_gnt : m1_gnt;
  endfunction

  function automatic logic rv_of(input int m);
    return (m == 0) ? m0_rvalid : m1_rvalid;
  endfunction

  function automatic logic [31:0] rd_of(input int m);
    return (m == 0) ? m0_rdata : m1_rdata;
  endfunction

  // Issues one request from an idle arbiter and times every event relative
  // to the first negedge after the request is raised.
  task automatic txn(input string tag, input int m, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     input int e_rt, input int e_wn, input int e_wt,
                     input logic [31:0] e_rd, input logic [AW-1:0] e_wa);
    int gt, wt, wn, rt;
    logic [31:0] rd;
    logic [AW-1:0] wa;
    gt = -1; wt = -1; wn = 0; rt = -1; rd = '0; wa = '0;
    @(posedge clk); #1;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d; be[m] = b;
    for (int t = 0; t < 20 && rt < 0; t++) begin
      @(negedge clk);
      if (ram_we) begin wn++; wt = t; wa = ram_addr; end
      if (gt < 0 && gnt_of(m)) gt = t;
      if (rv_of(m)) begin rt = t; rd = rd_of(m); end
      if (gt == t) begin @(posedge clk); #1; req[m] = 1'b0; end
    end
    req[m] = 1'b0;
    chk({tag, ".gnt_t"}, gt, 0);
    chk({tag, ".rv_lat"}, rt - gt, e_rt);
    chk({tag, ".we_cnt"}, wn, e_wn);
    if (e_wn > 0) begin
      chk({tag, ".we_lat"}, wt - gt, e_wt);
      chk({tag, ".we_addr"}, {{(32-AW){1'b0}}, wa}, {{(32-AW){1'b0}}, e_wa});
    end
    chk({tag, ".rdata"}, rd, e_rd);
    $display("txn %s m%0d we=%0d addr=%h be=%h gnt@%0d rvalid@%0d writes=%0d rdata=%h",
             tag, m, w, a, b, gt, rt, wn, rd);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    reset = 1'b1;
    req = 2'b00; we = 2'b00;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; be[i] = '0; end

    // Reset state, with a request pending to prove grants are held off
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.gnt",    {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst.rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst.we",     {31'd0, ram_we}, 32'd0);
    chk("rst.addr",   {{(32-AW){1'b0}}, ram_addr}, 32'd0);
    chk("rst.wdata",  ram_wdata, 32'd0);
    chk("rst.rdata",  m0_rdata | m1_rdata, 32'd0);
    @(posedge clk); #1;
    req[0] = 1'b0; reset = 1'b0;

    // Full-word store then load
    txn("t1.st", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 1, 1, 32'h0, 9'd4);
    chk("t1.mem4", mem[4], 32'hDEADBEEF);
    txn("t1.ld", 0, 1'b0, 32'h10, 32'h0, 4'h0, 2, 0, 0, 32'hDEADBEEF, 9'd0);

    // Partial store from m1: read-modify-write
    txn("t2.st", 1, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 3, 1, 2, 32'h0, 9'd4);
    chk("t2.mem4", mem[4], 32'hDEADAAEF);
    txn("t2.ld", 1, 1'b0, 32'h13, 32'h0, 4'h0, 2, 0, 0, 32'hDEADAAEF, 9'd0);

    // Simultaneous requests: tie goes to m0, then alternates
    @(posedge clk); #1;
    req = 2'b11; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h10;
    @(negedge clk);
    chk("t3.g0_first", {31'd0, m0_gnt}, 32'd1);
    chk("t3.g1_first", {31'd0, m1_gnt}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3.no_gnt_acc", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    @(negedge clk);
    chk("t3.rv0", {31'd0, m0_rvalid}, 32'd1);
    chk("t3.rd0", m0_rdata, 32'hDEADAAEF);
    @(negedge clk);
    chk("t3.g1_second", {31'd0, m1_gnt}, 32'd1);
    chk("t3.g0_second", {31'd0, m0_gnt}, 32'd0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3.rv1", {31'd0, m1_rvalid}, 32'd1);
    chk("t3.rd1", m1_rdata, 32'hDEADAAEF);
    @(negedge clk);
    chk("t3.g0_third", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3.rv0_b", {31'd0, m0_rvalid}, 32'd1);
    $display("txn t3 round-robin sequence m0,m1,m0 done");

    // Address wrap and be=0 store
    txn("t4.wrap", 0, 1'b1, 32'h800, 32'hCAFEF00D, 4'hF, 2, 1, 1, 32'h0, 9'd0);
    chk("t4.mem0", mem[0], 32'hCAFEF00D);
    txn("t4.be0", 0, 1'b1, 32'h800, 32'h12345678, 4'h0, 2, 0, 0, 32'h0, 9'd0);
    txn("t4.ld0", 0, 1'b0, 32'h0, 32'h0, 4'h0, 2, 0, 0, 32'hCAFEF00D, 9'd0);

    // m1 load waits behind m0 partial store and sees the merged word
    txn("t6.pre", 0, 1'b1, 32'h20, 32'h11223344, 4'hF, 2, 1, 1, 32'h0, 9'd8);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h00000055; be[0] = 4'b0001;
    @(negedge clk);
    chk("t6.g0", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
    @(negedge clk);
    chk("t6.acc_g1", {31'd0, m1_gnt}, 32'd0);
    @(negedge clk);
    chk("t6.mwr_we", {31'd0, ram_we}, 32'd1);
    chk("t6.mwr_data", ram_wdata, 32'h11223355);
    chk("t6.mwr_g1", {31'd0, m1_gnt}, 32'd0);
    @(negedge clk);
    chk("t6.rv0", {31'd0, m0_rvalid}, 32'd1);
    chk("t6.done_g1", {31'd0, m1_gnt}, 32'd0);
    @(negedge clk);
    chk("t6.g1", {31'd0, m1_gnt}, 32'd1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6.rv1", {31'd0, m1_rvalid}, 32'd1);
    chk("t6.rd1", m1_rdata, 32'h11223355);
    $display("txn t6 m1 load after m0 rmw rdata=%h", m1_rdata);

    // Reset during MWR aborts the write and the response
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h00770000; be[0] = 4'b0100;
    @(negedge clk);
    chk("t5.g0", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5.rst_we", {31'd0, ram_we}, 32'd0);
    chk("t5.rst_rv", {31'd0, m0_rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5.post_rv", {31'd0, m0_rvalid}, 32'd0);
    chk("t5.post_we", {31'd0, ram_we}, 32'd0);
    chk("t5.mem12", mem[12], 32'h0);
    $display("txn t5 reset in MWR, mem[12]=%h", mem[12]);
    txn("t5.ld", 1, 1'b0, 32'h30, 32'h0, 4'h0, 2, 0, 0, 32'h0, 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
